// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//   Time-multiplexed N-tap FIR controller. A single multiply-accumulate is
//   shared by all taps, one tap per cycle. The block owns the circular sample
//   history, the coefficient register file, the tap counter and the in/out
//   valid/ready handshakes.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   coef_we    in   coefficient write strobe (honoured only in IDLE)
//   coef_addr  in   tap index to write
//   coef_data  in   signed coefficient value
//   in_valid   in   x_in holds a sample
//   in_ready   out  block accepts a sample this cycle (IDLE)
//   x_in       in   signed input sample
//   out_valid  out  y_out holds a result
//   out_ready  in   consumer takes y_out this cycle
//   y_out      out  signed, saturated filter output
//   busy       out  high in MAC or OUT

module fir_mac_sequencer #(
  parameter int N     = 16,
  parameter int M     = 8,
  parameter int CW    = 8,
  parameter int SHIFT = CW - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coef_we,
  input  logic [$clog2(N)-1:0] coef_addr,
  input  logic [CW-1:0]        coef_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [M-1:0]         x_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [M-1:0]         y_out,
  output logic                 busy
);

  localparam int AW   = $clog2(N);
  localparam int PW   = M + CW;
  localparam int ACCW = PW + AW;

  localparam logic [AW-1:0]          LAST    = AW'(N - 1);
  localparam logic [AW:0]            N_W     = (AW + 1)'(N);
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2 ** (M - 1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-(2 ** (M - 1)));

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t state, state_next;

  logic signed [M-1:0]    hist [N];
  logic signed [CW-1:0]   coef [N];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          k;
  logic signed [ACCW-1:0] acc;

  logic [AW:0]            rd_wide;
  logic [AW-1:0]          rd_ptr;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] acc_next;
  logic signed [ACCW-1:0] shifted;
  logic [M-1:0]           sat_y;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // (wr_ptr - k) mod N, valid for any N, not just powers of two.
  always_comb begin
    rd_wide = {1'b0, wr_ptr} - {1'b0, k};
    if (k > wr_ptr) begin
      rd_wide = rd_wide + N_W;
    end
    rd_ptr = rd_wide[AW-1:0];
  end

  always_comb begin
    prod     = coef[k] * hist[rd_ptr];
    acc_next = acc + {{AW{prod[PW-1]}}, prod};
    shifted  = acc_next >>> SHIFT;
    if (shifted > SAT_MAX) begin
      sat_y = {1'b0, {(M-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat_y = {1'b1, {(M-1){1'b0}}};
    end else begin
      sat_y = shifted[M-1:0];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = MAC;
      MAC:     if (k == LAST) state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        hist[i] <= '0;
        coef[i] <= '0;
      end
      wr_ptr    <= '0;
      k         <= '0;
      acc       <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      // Writes outside IDLE are dropped; a write coinciding with acceptance
      // lands before the first MAC cycle reads the coefficient file.
      if (state == IDLE && coef_we) begin
        coef[coef_addr] <= coef_data;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            hist[wr_ptr] <= x_in;
            acc          <= '0;
            k            <= '0;
          end
        end
        MAC: begin
          acc <= acc_next;
          k   <= k + 1'b1;
          if (k == LAST) begin
            y_out     <= sat_y;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            wr_ptr    <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;

  logic       clk;
  logic       reset;
  logic       coef_we;
  logic [3:0] coef_addr;
  logic [7:0] coef_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y_out;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int m_coef [16];
  int m_x    [16];

  fir_mac_sequencer #(.N(16), .M(8), .CW(8), .SHIFT(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_coef[i] = 0;
      m_x[i]    = 0;
    end
  endtask

  // Direct-form reference: y = clamp(floor(sum c[k]*x[n-k] / 128)).
  function automatic logic [31:0] model_push(input logic [7:0] x);
    longint s;
    for (int i = 15; i > 0; i--) m_x[i] = m_x[i-1];
    m_x[0] = int'($signed(x));
    s = 0;
    for (int i = 0; i < 16; i++) s += longint'(m_coef[i]) * longint'(m_x[i]);
    s = s >>> 7;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return 32'(s) & 32'hFF;
  endfunction

  task automatic do_reset();
    reset     = 1'b0;
    coef_we   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    x_in      = '0;
    step();
    step();
    reset = 1'b1;
    model_clear();
  endtask

  task automatic write_coef(input logic [3:0] a, input logic [7:0] d);
    coef_addr = a;
    coef_data = d;
    coef_we   = 1'b1;
    step();
    coef_we = 1'b0;
    m_coef[a] = int'($signed(d));
  endtask

  task automatic load_all(input logic [7:0] d);
    for (int i = 0; i < 16; i++) write_coef(4'(i), d);
  endtask

  task automatic accept_sample(input logic [7:0] x, input string tag);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
    x_in     = x;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic finish_sample(input int lat0, input logic [7:0] expy, input string tag);
    int lat;
    lat = lat0;
    while (out_valid !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd16);
    check({tag, "_y"}, {24'b0, y_out}, {24'b0, expy});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic run_sample(input logic [7:0] x, input logic [7:0] expy, input string tag);
    accept_sample(x, tag);
    finish_sample(0, expy, tag);
  endtask

  initial begin
    logic [7:0] e;
    int         seen;
    int         n;
    int         lat;
    int         prev;
    logic [7:0] xr;
    logic [31:0] ey;

    // Reset state
    do_reset();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_y", {24'b0, y_out}, 32'd0);

    // 1. Impulse, all taps 0x40: 16 outputs of 0x3F, then 0x00
    load_all(8'h40);
    run_sample(8'h7F, 8'h3F, "imp0");
    for (int i = 1; i < 16; i++) run_sample(8'h00, 8'h3F, $sformatf("imp%0d", i));
    run_sample(8'h00, 8'h00, "imp16");

    // 2. Delay tap 3: three zeros, then 100/2 = 50
    do_reset();
    write_coef(4'd3, 8'h40);
    for (int i = 0; i < 6; i++)
      run_sample(8'd100, (i < 3) ? 8'h00 : 8'h32, $sformatf("dly%0d", i));

    // 3. Saturation: +127 ramp then -128 ramp
    do_reset();
    load_all(8'h7F);
    for (int i = 0; i < 16; i++)
      run_sample(8'h7F, (i == 0) ? 8'h7E : 8'h7F, $sformatf("satp%0d", i));
    for (int j = 1; j <= 16; j++) begin
      if (j <= 7)      e = 8'h7F;
      else if (j == 8) e = 8'hF8;
      else             e = 8'h80;
      run_sample(8'h80, e, $sformatf("satn%0d", j));
    end

    // 4. Backpressure
    do_reset();
    load_all(8'h40);
    accept_sample(8'h7F, "bp0");
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    check("bp0_lat", 32'(lat), 32'd16);
    x_in     = 8'h20;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp_hold_y%0d", i), {24'b0, y_out}, 32'h3F);
      check($sformatf("bp_hold_v%0d", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("bp_hold_rdy%0d", i), {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_v", {31'b0, out_valid}, 32'd0);
    check("bp_release_rdy", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_accept_busy", {31'b0, busy}, 32'd1);
    finish_sample(0, 8'h4F, "bp1");

    // 5. Write during MAC is dropped; same-cycle write+accept uses new value
    do_reset();
    load_all(8'h40);
    accept_sample(8'h7F, "ilA");
    step();
    coef_addr = 4'd0;
    coef_data = 8'h80;
    coef_we   = 1'b1;
    step();
    coef_we = 1'b0;
    finish_sample(2, 8'h3F, "ilA");
    run_sample(8'h7F, 8'h7F, "ilB");
    coef_addr = 4'd0;
    coef_data = 8'h80;
    coef_we   = 1'b1;
    accept_sample(8'h7F, "ilC");
    coef_we = 1'b0;
    finish_sample(0, 8'h00, "ilC");

    // Reset mid-MAC aborts
    accept_sample(8'h7F, "abD");
    repeat (5) step();
    reset = 1'b0;
    step();
    check("ab_out_valid", {31'b0, out_valid}, 32'd0);
    check("ab_busy", {31'b0, busy}, 32'd0);
    reset = 1'b1;
    model_clear();
    step();
    check("ab_in_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    repeat (20) begin
      step();
      if (out_valid !== 1'b0) seen++;
    end
    check("ab_no_output", 32'(seen), 32'd0);
    load_all(8'h40);
    run_sample(8'h7F, 8'h3F, "abimp0");
    run_sample(8'h00, 8'h3F, "abimp1");
    run_sample(8'h00, 8'h3F, "abimp2");

    // 6. Streaming with random coefficients and samples
    do_reset();
    for (int i = 0; i < 16; i++) write_coef(4'(i), 8'($urandom));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prev      = 0;
    for (int i = 0; i < 40; i++) begin
      xr   = 8'($urandom);
      x_in = xr;
      ey   = model_push(xr);
      n    = 0;
      while (in_ready !== 1'b1 && n < 100) begin
        step();
        n++;
      end
      step();
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
        step();
        lat++;
      end
      check($sformatf("st%0d_lat", i), 32'(lat), 32'd16);
      check($sformatf("st%0d_y", i), {24'b0, y_out}, ey);
      if (i > 0) check($sformatf("st%0d_period", i), 32'(cyc - prev), 32'd18);
      prev = cyc;
    end
    in_valid  = 1'b0;
    step();
    out_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
